bus_arbiter: RTL and testbench

Shares the single 16-bit external bus between the instruction fetch port (I) and the load/store port (D). Routes the granted master's address, size, write-enable and write data onto the bus, and steers ack_i back to that master only. Holds a grant for the whole transaction. D may lock the bus across a multi-halfword transfer. A watchdog releases the bus with an error when ack_i never arrives.

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one 16-bit external bus between the instruction
// fetch port (I) and the load/store port (D).
//
// Ports:
//   clk_i, reset_i               clock, synchronous active-high reset
//   i_adr_i, i_size_i            fetch request (size 00 = idle)
//   i_ack_o, i_err_o             fetch ack / watchdog error
//   d_adr_i, d_size_i, d_we_i,
//   d_dat_i, d_lock_i            load/store request, lock holds the grant
//   d_ack_o, d_err_o             load/store ack / watchdog error
//   adr_o, size_o, we_o, dat_o   external bus, driven by the granted master
//   vpa_o                        instruction-fetch cycle flag
//   ack_i                        external ack
//   gnt_o                        current grant: 00 none, 01 I, 10 D
//
// State table:
//   state | meaning
//   IDLE  | no owner; grant decided combinationally this cycle
//   OWN_I | fetch port owns the bus until ack, error or abandon
//   OWN_D | load/store port owns the bus (possibly locked across acks)
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] i_adr_i,
  input  logic [1:0]  i_size_i,
  output logic        i_ack_o,
  output logic        i_err_o,
  input  logic [63:0] d_adr_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_we_i,
  input  logic [15:0] d_dat_i,
  input  logic        d_lock_i,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [63:0] adr_o,
  output logic [1:0]  size_o,
  output logic        we_o,
  output logic [15:0] dat_o,
  output logic        vpa_o,
  input  logic        ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       last_d_q, last_d_d;
  logic [7:0] wdog_q, wdog_d;

  logic i_req, d_req;
  logic gnt_i, gnt_d, any_gnt;
  logic own_req, timeout;

  assign i_req = (i_size_i != 2'b00);
  assign d_req = (d_size_i != 2'b00);

  // Grant is combinational so a request is served in the cycle it appears.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          // Alternate on contention: D wins unless D took the last grant.
          gnt_d = ~last_d_q;
          gnt_i = last_d_q;
        end else begin
          gnt_i = i_req;
          gnt_d = d_req;
        end
      end
      OWN_I:   gnt_i = 1'b1;
      OWN_D:   gnt_d = 1'b1;
      default: ;
    endcase
  end

  assign any_gnt = gnt_i | gnt_d;
  assign own_req = (gnt_i & i_req) | (gnt_d & d_req);
  // ack_i in the same cycle takes priority over the timeout.
  assign timeout = own_req & ~ack_i & (wdog_q == WDOG_LAST);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    wdog_d   = wdog_q;
    if (state_q == IDLE && any_gnt) last_d_d = gnt_d;
    if (!any_gnt) begin
      state_d = IDLE;
      wdog_d  = 8'd0;
    end else if (ack_i) begin
      state_d = (gnt_d && d_lock_i) ? OWN_D : IDLE;
      wdog_d  = 8'd0;
    end else if (own_req) begin
      if (timeout) begin
        state_d = IDLE;
        wdog_d  = 8'd0;
      end else begin
        state_d = gnt_d ? OWN_D : OWN_I;
        wdog_d  = wdog_q + 8'd1;
      end
    end else if (gnt_d && d_lock_i) begin
      // Locked D pausing between beats: keep the bus, watchdog frozen.
      state_d = OWN_D;
    end else begin
      state_d = IDLE;
      wdog_d  = 8'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wdog_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wdog_q   <= wdog_d;
    end
  end

  // All outputs are held at zero while reset is asserted.
  logic act_i, act_d;
  assign act_i = gnt_i & ~reset_i;
  assign act_d = gnt_d & ~reset_i;

  assign gnt_o   = {act_d, act_i};
  assign adr_o   = act_i ? i_adr_i : (act_d ? d_adr_i : 64'd0);
  assign size_o  = act_i ? i_size_i : (act_d ? d_size_i : 2'b00);
  assign we_o    = act_d & d_we_i;
  assign dat_o   = act_d ? d_dat_i : 16'd0;
  assign vpa_o   = act_i & i_req;
  assign i_ack_o = act_i & ack_i;
  assign d_ack_o = act_d & ack_i;
  assign i_err_o = act_i & timeout;
  assign d_err_o = act_d & timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] i_adr_i;
  logic [1:0]  i_size_i;
  logic        i_ack_o, i_err_o;
  logic [63:0] d_adr_i;
  logic [1:0]  d_size_i;
  logic        d_we_i;
  logic [15:0] d_dat_i;
  logic        d_lock_i;
  logic        d_ack_o, d_err_o;
  logic [63:0] adr_o;
  logic [1:0]  size_o;
  logic        we_o;
  logic [15:0] dat_o;
  logic        vpa_o;
  logic        ack_i;
  logic [1:0]  gnt_o;

  bus_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .i_adr_i(i_adr_i), .i_size_i(i_size_i), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_adr_i(d_adr_i), .d_size_i(d_size_i), .d_we_i(d_we_i), .d_dat_i(d_dat_i),
    .d_lock_i(d_lock_i), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .adr_o(adr_o), .size_o(size_o), .we_o(we_o), .dat_o(dat_o), .vpa_o(vpa_o),
    .ack_i(ack_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        vpa, we, iack, dack, ierr, derr;
    logic [63:0] adr;
    logic [1:0]  size;
    logic [15:0] dat;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected grant/ack/err are given per step; bus routing follows from the
  // expected grant and the inputs currently driven.
  task automatic step(input string tag, input logic [1:0] g,
                      input logic ia, input logic da, input logic ie, input logic de);
    obs_t e, o;
    e.gnt  = g;
    e.iack = ia; e.dack = da; e.ierr = ie; e.derr = de;
    e.vpa  = (g == 2'b01) && (i_size_i != 2'b00);
    e.we   = (g == 2'b10) && d_we_i;
    e.adr  = (g == 2'b01) ? i_adr_i  : (g == 2'b10) ? d_adr_i  : 64'd0;
    e.size = (g == 2'b01) ? i_size_i : (g == 2'b10) ? d_size_i : 2'b00;
    e.dat  = (g == 2'b10) ? d_dat_i : 16'd0;
    sb_q.push_back(e);
    @(negedge clk_i);
    o = '{gnt_o, vpa_o, we_o, i_ack_o, d_ack_o, i_err_o, d_err_o, adr_o, size_o, dat_o};
    e = sb_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; ack_i = 1'b1;
    i_adr_i = 64'h0000_0000_0000_1000; i_size_i = 2'b10;
    d_adr_i = 64'h0000_0000_0000_2000; d_size_i = 2'b10;
    d_we_i = 1'b1; d_dat_i = 16'h5A5A; d_lock_i = 1'b0;
    #1;
    step("reset0", 2'b00, 0, 0, 0, 0);
    step("reset1", 2'b00, 0, 0, 0, 0);
    reset_i = 1'b0; ack_i = 1'b0; i_size_i = 2'b00; d_size_i = 2'b00;

    // I alone, ack on the 3rd cycle
    i_size_i = 2'b10; i_adr_i = 64'hFFFF_FFFF_FFFF_FF00;
    step("i_alone_c1", 2'b01, 0, 0, 0, 0);
    step("i_alone_c2", 2'b01, 0, 0, 0, 0);
    ack_i = 1'b1;
    step("i_alone_ack", 2'b01, 1, 0, 0, 0);
    ack_i = 1'b0; i_size_i = 2'b00;
    step("i_alone_idle", 2'b00, 0, 0, 0, 0);

    // Contention alternates through last_d
    i_size_i = 2'b10; d_size_i = 2'b10; d_we_i = 1'b1; d_dat_i = 16'h1234;
    d_adr_i = 64'h0000_0000_0000_0100;
    step("both_d_first", 2'b10, 0, 0, 0, 0);
    ack_i = 1'b1;
    step("both_d_ack", 2'b10, 0, 1, 0, 0);
    ack_i = 1'b0;
    step("both_i_next", 2'b01, 0, 0, 0, 0);
    ack_i = 1'b1;
    step("both_i_ack", 2'b01, 1, 0, 0, 0);
    ack_i = 1'b0;
    step("both_d_again", 2'b10, 0, 0, 0, 0);
    ack_i = 1'b1;
    step("both_d_ack2", 2'b10, 0, 1, 0, 0);
    ack_i = 1'b0; i_size_i = 2'b00; d_size_i = 2'b00;
    step("both_idle", 2'b00, 0, 0, 0, 0);

    // Locked D burst of 4 halfword stores, I requesting from the 1st ack on
    d_size_i = 2'b10; d_lock_i = 1'b1; d_we_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_dat_i = 16'hA000 + 16'(k);
      d_adr_i = 64'h0000_0000_0000_3000 + 64'(2 * k);
      ack_i = 1'b0;
      step($sformatf("lock_wait%0d", k), 2'b10, 0, 0, 0, 0);
      i_size_i = 2'b10;
      ack_i = 1'b1;
      if (k == 3) d_lock_i = 1'b0;
      step($sformatf("lock_ack%0d", k), 2'b10, 0, 1, 0, 0);
    end
    ack_i = 1'b0; d_size_i = 2'b00;
    step("lock_i_after", 2'b01, 0, 0, 0, 0);
    ack_i = 1'b1;
    step("lock_i_ack", 2'b01, 1, 0, 0, 0);
    ack_i = 1'b0; i_size_i = 2'b00;
    step("lock_idle", 2'b00, 0, 0, 0, 0);

    // Watchdog: I alone, then D pending; error on 8th granted cycle
    i_size_i = 2'b10;
    step("wd_c1", 2'b01, 0, 0, 0, 0);
    d_size_i = 2'b10; d_we_i = 1'b0;
    for (int c = 2; c <= 7; c++) step($sformatf("wd_c%0d", c), 2'b01, 0, 0, 0, 0);
    step("wd_err", 2'b01, 0, 0, 1, 0);
    step("wd_d_granted", 2'b10, 0, 0, 0, 0);
    ack_i = 1'b1; i_size_i = 2'b00;
    step("wd_d_ack", 2'b10, 0, 1, 0, 0);
    ack_i = 1'b0; d_size_i = 2'b00;
    step("wd_idle", 2'b00, 0, 0, 0, 0);

    // Reset in OWN_D with ack on the same cycle
    d_size_i = 2'b10; d_we_i = 1'b1;
    step("rst_d_c1", 2'b10, 0, 0, 0, 0);
    step("rst_d_c2", 2'b10, 0, 0, 0, 0);
    reset_i = 1'b1; ack_i = 1'b1; i_size_i = 2'b10;
    step("rst_mid", 2'b00, 0, 0, 0, 0);
    reset_i = 1'b0; ack_i = 1'b0;
    step("rst_contend_d", 2'b10, 0, 0, 0, 0);
    ack_i = 1'b1;
    step("rst_d_ack", 2'b10, 0, 1, 0, 0);
    ack_i = 1'b0; i_size_i = 2'b00; d_size_i = 2'b00;
    step("rst_idle", 2'b00, 0, 0, 0, 0);

    // I abandons after 2 cycles; watchdog restarts from 0
    i_size_i = 2'b01;
    step("ab_c1", 2'b01, 0, 0, 0, 0);
    step("ab_c2", 2'b01, 0, 0, 0, 0);
    i_size_i = 2'b00;
    step("ab_drop", 2'b01, 0, 0, 0, 0);
    step("ab_idle", 2'b00, 0, 0, 0, 0);
    i_size_i = 2'b10;
    for (int c = 1; c <= 7; c++) step($sformatf("ab_wd_c%0d", c), 2'b01, 0, 0, 0, 0);
    step("ab_wd_err", 2'b01, 0, 0, 1, 0);
    i_size_i = 2'b00;
    step("ab_wd_idle", 2'b00, 0, 0, 0, 0);

    // Locked D drops its request: bus held one cycle, then released
    d_size_i = 2'b11; d_lock_i = 1'b1; d_we_i = 1'b0;
    step("ld_req", 2'b10, 0, 0, 0, 0);
    ack_i = 1'b1;
    step("ld_ack", 2'b10, 0, 1, 0, 0);
    ack_i = 1'b0; d_size_i = 2'b00;
    step("ld_hold", 2'b10, 0, 0, 0, 0);
    d_lock_i = 1'b0;
    step("ld_release", 2'b10, 0, 0, 0, 0);
    step("ld_idle", 2'b00, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
